// File: rtl/alu_issue_stage_pkg.sv
// Shared constants for the ALU issue stage: widths, instruction field positions, opcode map.
package alu_issue_stage_pkg;

  localparam int unsigned DataW    = 32;
  localparam int unsigned NumRegs  = 8;
  localparam int unsigned RegAddrW = 3;
  localparam int unsigned ImmW     = 17;

  // Instruction field bit positions
  localparam int unsigned FldOpcLo  = 0;
  localparam int unsigned FldOpcHi  = 2;
  localparam int unsigned FldSub    = 3;
  localparam int unsigned FldUseCin = 4;
  localparam int unsigned FldRdLo   = 5;
  localparam int unsigned FldRdHi   = 7;
  localparam int unsigned FldRs1Lo  = 8;
  localparam int unsigned FldRs1Hi  = 10;
  localparam int unsigned FldRs2Lo  = 11;
  localparam int unsigned FldRs2Hi  = 13;
  localparam int unsigned FldImmSel = 14;
  localparam int unsigned FldImmLo  = 15;
  localparam int unsigned FldImmHi  = 31;

  typedef enum logic [2:0] {
    OpAdd  = 3'b000,
    OpXor  = 3'b001,
    OpAnd  = 3'b010,
    OpOr   = 3'b011,
    OpNor  = 3'b100,
    OpSl   = 3'b101,
    OpSr   = 3'b110,
    OpRsvd = 3'b111
  } alu_op_e;

  function automatic logic is_illegal_op(input logic [2:0] opc);
    return opc == OpRsvd;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// 8 x 32 register file: two asynchronous reads, one synchronous write, r0 hardwired to zero.
module alu_regfile
  import alu_issue_stage_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [RegAddrW-1:0] raddr_a,
  input  logic [RegAddrW-1:0] raddr_b,
  output logic [DataW-1:0]    rdata_a,
  output logic [DataW-1:0]    rdata_b,
  input  logic                we,
  input  logic [RegAddrW-1:0] waddr,
  input  logic [DataW-1:0]    wdata
);

  // Entry 0 is never written and stays zero.
  logic [DataW-1:0] regs_q [NumRegs];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NumRegs; i++) regs_q[i] <= '0;
    end else if (we && waddr != '0) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 : regs_q[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : regs_q[raddr_b];

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decode, operand read, single output register with valid/ready handshake.
// Define ALU_ISSUE_BYPASS_EN to forward same-cycle writeback data and carry into the operands.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [31:0]         in_instr,
  output logic                in_ready,
  output logic [DataW-1:0]    alu_a,
  output logic [DataW-1:0]    alu_b,
  output logic [2:0]          alu_opcode,
  output logic                alu_sub,
  output logic                alu_cin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [RegAddrW-1:0] out_rd,
  output logic                out_illegal,
  input  logic                wb_en,
  input  logic [RegAddrW-1:0] wb_addr,
  input  logic [DataW-1:0]    wb_data,
  input  logic                wb_carry_we,
  input  logic                wb_cout
);

  logic [2:0]          dec_opc;
  logic                dec_sub;
  logic                dec_use_cin;
  logic [RegAddrW-1:0] dec_rd;
  logic [RegAddrW-1:0] dec_rs1;
  logic [RegAddrW-1:0] dec_rs2;
  logic                dec_imm_sel;
  logic [ImmW-1:0]     dec_imm;

  assign dec_opc     = in_instr[FldOpcHi:FldOpcLo];
  assign dec_sub     = in_instr[FldSub];
  assign dec_use_cin = in_instr[FldUseCin];
  assign dec_rd      = in_instr[FldRdHi:FldRdLo];
  assign dec_rs1     = in_instr[FldRs1Hi:FldRs1Lo];
  assign dec_rs2     = in_instr[FldRs2Hi:FldRs2Lo];
  assign dec_imm_sel = in_instr[FldImmSel];
  assign dec_imm     = in_instr[FldImmHi:FldImmLo];

  logic [DataW-1:0] rf_a;
  logic [DataW-1:0] rf_b;

  alu_regfile u_regfile (
    .clk     (clk),
    .rst     (rst),
    .raddr_a (dec_rs1),
    .raddr_b (dec_rs2),
    .rdata_a (rf_a),
    .rdata_b (rf_b),
    .we      (wb_en),
    .waddr   (wb_addr),
    .wdata   (wb_data)
  );

  logic carry_q;

  always_ff @(posedge clk) begin
    if (rst)              carry_q <= 1'b0;
    else if (wb_carry_we) carry_q <= wb_cout;
  end

  logic [DataW-1:0] op_a;
  logic [DataW-1:0] op_rs2;
  logic             carry_eff;

`ifdef ALU_ISSUE_BYPASS_EN
  always_comb begin
    op_a      = rf_a;
    op_rs2    = rf_b;
    carry_eff = carry_q;
    if (wb_en && wb_addr != '0 && wb_addr == dec_rs1) op_a   = wb_data;
    if (wb_en && wb_addr != '0 && wb_addr == dec_rs2) op_rs2 = wb_data;
    if (wb_carry_we) carry_eff = wb_cout;
  end
`else
  // Pre-write values; software keeps a one-cycle gap after a dependent writeback.
  assign op_a      = rf_a;
  assign op_rs2    = rf_b;
  assign carry_eff = carry_q;
`endif

  logic accept;

  assign in_ready = !rst && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_opcode  <= '0;
      alu_sub     <= 1'b0;
      alu_cin     <= 1'b0;
      out_rd      <= '0;
      out_illegal <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      alu_a       <= op_a;
      alu_b       <= dec_imm_sel ? {{(DataW-ImmW){1'b0}}, dec_imm} : op_rs2;
      alu_opcode  <= dec_opc;
      alu_sub     <= dec_sub;
      alu_cin     <= dec_use_cin & carry_eff;
      out_rd      <= dec_rd;
      out_illegal <= is_illegal_op(dec_opc);
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage; expected values are hand-computed.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_opcode;
  logic        alu_sub;
  logic        alu_cin;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_rd;
  logic        out_illegal;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_carry_we;
  logic        wb_cout;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_instr    (in_instr),
    .in_ready    (in_ready),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_opcode  (alu_opcode),
    .alu_sub     (alu_sub),
    .alu_cin     (alu_cin),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_rd      (out_rd),
    .out_illegal (out_illegal),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .wb_carry_we (wb_carry_we),
    .wb_cout     (wb_cout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] opc, input logic sub, input logic cin,
                                     input logic [2:0] rd, input logic [2:0] rs1,
                                     input logic [2:0] rs2, input logic imm_sel,
                                     input logic [16:0] imm);
    return {imm, imm_sel, rs2, rs1, rd, cin, sub, opc};
  endfunction

  // Advance past the next rising edge; outputs are then sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [2:0] addr, input logic [31:0] data);
    wb_en = 1'b1; wb_addr = addr; wb_data = data;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic issue(input logic [31:0] instr);
    in_valid = 1'b1; in_instr = instr;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_instr = mk(3'd0, 1'b0, 1'b0, 3'd1, 3'd0, 3'd0, 1'b0, 17'd0);
    out_ready = 1'b1; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    wb_carry_we = 1'b0; wb_cout = 1'b0;
    tick(); tick();
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    in_valid = 1'b0; rst = 1'b0;
    tick();
    check("idle_in_ready", {31'b0, in_ready}, 32'd1);
    check("idle_out_valid", {31'b0, out_valid}, 32'd0);

    // Same-cycle carry writeback and use_cin issue
    wb_carry_we = 1'b1; wb_cout = 1'b1;
    issue(mk(3'd0, 1'b0, 1'b1, 3'd1, 3'd0, 3'd0, 1'b0, 17'd0));
    wb_carry_we = 1'b0;
`ifdef ALU_ISSUE_BYPASS_EN
    check("carry_same_cycle", {31'b0, alu_cin}, 32'd1);
`else
    check("carry_same_cycle", {31'b0, alu_cin}, 32'd0);
`endif

    wb(3'd1, 32'd5);
    wb(3'd2, 32'd10);
    issue(mk(3'd0, 1'b0, 1'b0, 3'd3, 3'd1, 3'd2, 1'b0, 17'd0));
    check("add_valid", {31'b0, out_valid}, 32'd1);
    check("add_a", alu_a, 32'd5);
    check("add_b", alu_b, 32'd10);
    check("add_opc", {29'b0, alu_opcode}, 32'd0);
    check("add_cin", {31'b0, alu_cin}, 32'd0);
    check("add_rd", {29'b0, out_rd}, 32'd3);
    check("add_illegal", {31'b0, out_illegal}, 32'd0);
    tick();
    check("drain_valid", {31'b0, out_valid}, 32'd0);

    issue(mk(3'd0, 1'b0, 1'b1, 3'd1, 3'd1, 3'd2, 1'b0, 17'd0));
    check("cin_set", {31'b0, alu_cin}, 32'd1);
    issue(mk(3'd0, 1'b1, 1'b0, 3'd1, 3'd1, 3'd2, 1'b0, 17'd0));
    check("cin_clear", {31'b0, alu_cin}, 32'd0);
    check("sub_bit", {31'b0, alu_sub}, 32'd1);

    issue(mk(3'd1, 1'b0, 1'b0, 3'd2, 3'd1, 3'd0, 1'b1, 17'd9));
    check("xor_a", alu_a, 32'd5);
    check("xor_b", alu_b, 32'd9);
    check("xor_opc", {29'b0, alu_opcode}, 32'd1);

    // Stall: downstream not ready, new instruction waiting
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = mk(3'd3, 1'b0, 1'b0, 3'd5, 3'd2, 3'd1, 1'b0, 17'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("stall_in_ready", {31'b0, in_ready}, 32'd0);
      check("stall_valid", {31'b0, out_valid}, 32'd1);
      check("stall_opc", {29'b0, alu_opcode}, 32'd1);
      check("stall_b", alu_b, 32'd9);
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    check("b2b_valid", {31'b0, out_valid}, 32'd1);
    check("b2b_opc", {29'b0, alu_opcode}, 32'd3);
    check("b2b_a", alu_a, 32'd10);
    check("b2b_b", alu_b, 32'd5);
    check("b2b_rd", {29'b0, out_rd}, 32'd5);
    in_instr = mk(3'd6, 1'b0, 1'b0, 3'd6, 3'd2, 3'd0, 1'b1, 17'h1ffff);
    tick();
    in_valid = 1'b0;
    check("b2b2_valid", {31'b0, out_valid}, 32'd1);
    check("b2b2_opc", {29'b0, alu_opcode}, 32'd6);
    check("imm_max_b", alu_b, 32'h0001ffff);
    tick();
    check("empty_valid", {31'b0, out_valid}, 32'd0);

    // Same-cycle writeback of R4 and issue reading R4
    wb_en = 1'b1; wb_addr = 3'd4; wb_data = 32'd7;
    issue(mk(3'd0, 1'b0, 1'b0, 3'd1, 3'd4, 3'd0, 1'b0, 17'd0));
    wb_en = 1'b0;
`ifdef ALU_ISSUE_BYPASS_EN
    check("fwd_a", alu_a, 32'd7);
`else
    check("fwd_a", alu_a, 32'd0);
`endif
    check("fwd_r0_b", alu_b, 32'd0);
    issue(mk(3'd0, 1'b0, 1'b0, 3'd1, 3'd4, 3'd4, 1'b0, 17'd0));
    check("r4_a", alu_a, 32'd7);
    check("r4_b", alu_b, 32'd7);

    wb(3'd0, 32'd99);
    issue(mk(3'd0, 1'b0, 1'b0, 3'd1, 3'd0, 3'd1, 1'b0, 17'd0));
    check("r0_zero", alu_a, 32'd0);
    check("r1_b", alu_b, 32'd5);

    issue(mk(3'd7, 1'b0, 1'b0, 3'd7, 3'd2, 3'd1, 1'b0, 17'd0));
    check("ill_flag", {31'b0, out_illegal}, 32'd1);
    check("ill_opc", {29'b0, alu_opcode}, 32'd7);
    check("ill_a", alu_a, 32'd10);

    // Reset while output pending; reset also beats a writeback to R1
    out_ready = 1'b0; rst = 1'b1; in_valid = 1'b1;
    wb_en = 1'b1; wb_addr = 3'd1; wb_data = 32'd77;
    tick();
    wb_en = 1'b0;
    check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_illegal", {31'b0, out_illegal}, 32'd0);
    check("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b0; out_ready = 1'b1;
    issue(mk(3'd0, 1'b0, 1'b1, 3'd1, 3'd1, 3'd2, 1'b0, 17'd0));
    check("post_rst_r1", alu_a, 32'd0);
    check("post_rst_r2", alu_b, 32'd0);
    check("post_rst_cin", {31'b0, alu_cin}, 32'd0);
    check("post_rst_valid", {31'b0, out_valid}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
